rob_commit_regfile: RTL

- Architectural register file with per-register rename status. It is the consumer end of the ROB-to-regfile commit bus.
- At issue it records, per destination register, which ROB entry will produce that register's value. At commit it writes the retired value and releases the rename when the tags match.
- It serves two source-operand lookups (value, busy, tag) to the issue/reservation-station stage.

---
 rtl/rob_commit_regfile_if.sv | 38 +++
 rtl/rob_commit_regfile.sv | 79 +++++++
 2 files changed

// File: rtl/rob_commit_regfile_if.sv
// Issue, commit and operand lookup bus between the ROB/issue stage
// and the architectural register file.
interface rob_commit_regfile_if #(
    parameter int DATA_W    = 32,
    parameter int ROB_IDX_W = 5,
    parameter int REG_W     = 5
);
    logic                 issue;
    logic [REG_W-1:0]     issue_rd;
    logic [ROB_IDX_W-1:0] issue_rob_idx;
    logic                 commit_valid;
    logic [DATA_W-1:0]    commit_value;
    logic [ROB_IDX_W-1:0] commit_rob_idx;
    logic [REG_W-1:0]     commit_regfile_idx;
    logic                 flush;
    logic [REG_W-1:0]     rs1_idx;
    logic [REG_W-1:0]     rs2_idx;
    logic [DATA_W-1:0]    rs1_value;
    logic [DATA_W-1:0]    rs2_value;
    logic                 rs1_busy;
    logic                 rs2_busy;
    logic [ROB_IDX_W-1:0] rs1_tag;
    logic [ROB_IDX_W-1:0] rs2_tag;

    modport master (
        output issue, issue_rd, issue_rob_idx,
        output commit_valid, commit_value, commit_rob_idx, commit_regfile_idx,
        output flush, rs1_idx, rs2_idx,
        input  rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_tag, rs2_tag
    );

    modport slave (
        input  issue, issue_rd, issue_rob_idx,
        input  commit_valid, commit_value, commit_rob_idx, commit_regfile_idx,
        input  flush, rs1_idx, rs2_idx,
        output rs1_value, rs2_value, rs1_busy, rs2_busy, rs1_tag, rs2_tag
    );
endinterface

// File: rtl/rob_commit_regfile.sv
// Architectural register file with per-register rename tag/busy,
// written by the ROB commit bus, with zero-latency commit bypass.
module rob_commit_regfile #(
    parameter int NUM_REGS  = 32,
    parameter int DATA_W    = 32,
    parameter int ROB_IDX_W = 5
) (
    input logic clk,
    input logic rst,
    rob_commit_regfile_if.slave bus
);
    localparam int REG_W = $clog2(NUM_REGS);

    typedef struct packed {
        logic [DATA_W-1:0]    value;
        logic                 busy;
        logic [ROB_IDX_W-1:0] tag;
    } rd_t;

    logic [DATA_W-1:0]    value_q [NUM_REGS];
    logic                 busy_q  [NUM_REGS];
    logic [ROB_IDX_W-1:0] tag_q   [NUM_REGS];

    rd_t rs1;
    rd_t rs2;

    // Commit writes the value; issue (unless flushed) takes ownership last.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                value_q[r] <= '0;
                busy_q[r]  <= 1'b0;
                tag_q[r]   <= '0;
            end
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (bus.commit_valid && bus.commit_regfile_idx == REG_W'(r)) begin
                    value_q[r] <= bus.commit_value;
                    if (busy_q[r] && tag_q[r] == bus.commit_rob_idx)
                        busy_q[r] <= 1'b0;
                end
                if (bus.flush) begin
                    busy_q[r] <= 1'b0;
                end else if (bus.issue && bus.issue_rd == REG_W'(r)) begin
                    busy_q[r] <= 1'b1;
                    tag_q[r]  <= bus.issue_rob_idx;
                end
            end
        end
    end

    function automatic rd_t read_port(input logic [REG_W-1:0] idx);
        rd_t o;
        o.value = value_q[idx];
        o.busy  = busy_q[idx];
        o.tag   = tag_q[idx];
        if (bus.commit_valid && bus.commit_regfile_idx == idx) begin
            o.value = bus.commit_value;
            if (o.busy && o.tag == bus.commit_rob_idx)
                o.busy = 1'b0;
        end
        if (idx == '0)
            o = '0;
        return o;
    endfunction

    // Operand lookups see stored state plus the in-flight commit only.
    always_comb begin
        rs1 = read_port(bus.rs1_idx);
        rs2 = read_port(bus.rs2_idx);
    end

    assign bus.rs1_value = rs1.value;
    assign bus.rs1_busy  = rs1.busy;
    assign bus.rs1_tag   = rs1.tag;
    assign bus.rs2_value = rs2.value;
    assign bus.rs2_busy  = rs2.busy;
    assign bus.rs2_tag   = rs2.tag;
endmodule
